// File: rtl/huff_pkg.sv
// Shared types for the Huffman tree builder.
//   NODE_W/KEY_MSB/KEY_LSB : node layout, key = node[KEY_MSB:KEY_LSB]
//   node_t                 : 13-bit node {8-bit freq key, 5-bit id}
//   state_e                : sort_3 FSM states
//   key_of()               : extracts the unsigned compare key
package huff_pkg;
  localparam int NODE_W  = 13;
  localparam int KEY_MSB = 12;
  localparam int KEY_LSB = 5;
  localparam int KEY_W   = KEY_MSB - KEY_LSB + 1;

  typedef logic [NODE_W-1:0] node_t;
  typedef logic [KEY_W-1:0]  key_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAP  = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DONE = 3'd5
  } state_e;

  function automatic key_t key_of(input node_t n);
    return n[KEY_MSB:KEY_LSB];
  endfunction
endpackage

// File: rtl/sort_3_if.sv
// Node/handshake bundle between the insertion sorter and sort_3.
//   sort_begin      : start request (rising edge starts a sort)
//   node1..node3    : unsorted nodes
//   new1..new3      : sorted nodes, ascending key
//   sort_over       : result valid, level, held in DONE
interface sort_3_if;
  import huff_pkg::*;
  logic  sort_begin;
  node_t node1, node2, node3;
  node_t new1, new2, new3;
  logic  sort_over;

  modport master (output sort_begin, node1, node2, node3,
                  input  new1, new2, new3, sort_over);
  modport slave  (input  sort_begin, node1, node2, node3,
                  output new1, new2, new3, sort_over);
endinterface

// File: rtl/cmp_swap.sv
// Combinational compare-exchange of two nodes on the unsigned key.
//   a_i : upper (earlier in input order) node
//   b_i : lower node
//   lo_o/hi_o : smaller / larger key; ties keep a_i first (stable)
module cmp_swap
  import huff_pkg::*;
(
  input  node_t a_i,
  input  node_t b_i,
  output node_t lo_o,
  output node_t hi_o
);
  logic swap;

  // strict '>' keeps equal keys in input order
  assign swap = key_of(a_i) > key_of(b_i);
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;
endmodule

// File: rtl/sort_3.sv
// Three-node sorter: captures node1..3, runs a 3-step odd-even network
// (w1,w2) (w2,w3) (w1,w2) through one shared cmp_swap, then publishes
// new1..new3 and holds sort_over until the next accepted start.
//   CLK  : rising-edge clock
//   nRST : asynchronous active-low reset
//   bus  : sort_3_if slave (sort_begin, node1..3, new1..3, sort_over)
module sort_3
  import huff_pkg::*;
(
  input  logic      CLK,
  input  logic      nRST,
  sort_3_if.slave   bus
);
  state_e state_q;
  logic   sb_q;
  node_t  w1_q, w2_q, w3_q;
  node_t  new1_q, new2_q, new3_q;
  logic   over_q;

  logic   start;
  node_t  op_a, op_b, lo, hi;

  assign start = bus.sort_begin & ~sb_q;

  // S2 works on (w2,w3); S1 and S3 both work on (w1,w2)
  always_comb begin
    op_a = w1_q;
    op_b = w2_q;
    if (state_q == S2) begin
      op_a = w2_q;
      op_b = w3_q;
    end
  end

  cmp_swap u_cmp (
    .a_i  (op_a),
    .b_i  (op_b),
    .lo_o (lo),
    .hi_o (hi)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      sb_q    <= 1'b0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      new1_q  <= '0;
      new2_q  <= '0;
      new3_q  <= '0;
      over_q  <= 1'b0;
    end else begin
      sb_q <= bus.sort_begin;
      case (state_q)
        IDLE, DONE: if (start) state_q <= CAP;
        CAP: begin
          w1_q    <= bus.node1;
          w2_q    <= bus.node2;
          w3_q    <= bus.node3;
          over_q  <= 1'b0;
          state_q <= S1;
        end
        S1: begin
          w1_q    <= lo;
          w2_q    <= hi;
          state_q <= S2;
        end
        S2: begin
          w2_q    <= lo;
          w3_q    <= hi;
          state_q <= S3;
        end
        S3: begin
          w1_q    <= lo;
          w2_q    <= hi;
          new1_q  <= lo;
          new2_q  <= hi;
          new3_q  <= w3_q;
          over_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.new1      = new1_q;
  assign bus.new2      = new2_q;
  assign bus.new3      = new3_q;
  assign bus.sort_over = over_q;
endmodule

// File: tb/tb_sort_3.sv
// Directed bench for sort_3: hand-computed vectors, immediate assertions.
module tb_sort_3;
  import huff_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   tests = 0;
  int   fails = 0;
  node_t last1, last2, last3;
  logic  last_over;

  sort_3_if bus ();

  sort_3 dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  function automatic node_t mk(input logic [7:0] k, input logic [4:0] id);
    return {k, id};
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Start edge, then E0..E3; inputs are scrambled after E0 to prove
  // they are sampled only at capture. hold keeps sort_begin high.
  task automatic run_sort(input string tag, input node_t a, b, c,
                          input node_t x, y, z, input bit hold);
    bus.node1 = a; bus.node2 = b; bus.node3 = c;
    bus.sort_begin = 1'b1;
    cyc();                                   // start edge seen
    if (!hold) bus.sort_begin = 1'b0;
    chk({tag, "_pre_over"}, 13'(bus.sort_over), 13'(last_over));
    cyc();                                   // E0
    bus.node1 = mk(8'h77, 5'd30); bus.node2 = mk(8'h01, 5'd29); bus.node3 = mk(8'hEE, 5'd28);
    chk({tag, "_e0_over"}, 13'(bus.sort_over), 13'd0);
    cyc();                                   // E1
    cyc();                                   // E2
    chk({tag, "_e2_over"}, 13'(bus.sort_over), 13'd0);
    chk({tag, "_e2_hold1"}, bus.new1, last1);
    chk({tag, "_e2_hold3"}, bus.new3, last3);
    cyc();                                   // E3
    chk({tag, "_e3_over"}, 13'(bus.sort_over), 13'd1);
    chk({tag, "_new1"}, bus.new1, x);
    chk({tag, "_new2"}, bus.new2, y);
    chk({tag, "_new3"}, bus.new3, z);
    last1 = x; last2 = y; last3 = z; last_over = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    bus.sort_begin = 1'b0;
    bus.node1 = '0; bus.node2 = '0; bus.node3 = '0;
    last1 = '0; last2 = '0; last3 = '0; last_over = 1'b0;
    #1;
    chk("rst_new1", bus.new1, 13'd0);
    chk("rst_new2", bus.new2, 13'd0);
    chk("rst_new3", bus.new3, 13'd0);
    chk("rst_over", 13'(bus.sort_over), 13'd0);
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;
    cyc();

    // T1 distinct keys
    run_sort("t1", mk(8'h30, 5'd1), mk(8'h10, 5'd2), mk(8'h20, 5'd3),
             mk(8'h10, 5'd2), mk(8'h20, 5'd3), mk(8'h30, 5'd1), 1'b0);
    cyc();
    // T2 reverse order, key extremes
    run_sort("t2", mk(8'hFF, 5'd1), mk(8'h80, 5'd2), mk(8'h00, 5'd3),
             mk(8'h00, 5'd3), mk(8'h80, 5'd2), mk(8'hFF, 5'd1), 1'b0);
    cyc();
    // T3 all keys equal: stable
    run_sort("t3", mk(8'h05, 5'd7), mk(8'h05, 5'd8), mk(8'h05, 5'd9),
             mk(8'h05, 5'd7), mk(8'h05, 5'd8), mk(8'h05, 5'd9), 1'b0);
    cyc();
    // partial tie: node1/node3 tie, node2 smallest
    run_sort("tie2", mk(8'h40, 5'd4), mk(8'h11, 5'd5), mk(8'h40, 5'd6),
             mk(8'h11, 5'd5), mk(8'h40, 5'd4), mk(8'h40, 5'd6), 1'b0);
    cyc();

    // T4 sort_begin held high: one sort only, result kept
    run_sort("t4", mk(8'h22, 5'd10), mk(8'h33, 5'd11), mk(8'h11, 5'd12),
             mk(8'h11, 5'd12), mk(8'h22, 5'd10), mk(8'h33, 5'd11), 1'b1);
    repeat (15) cyc();
    chk("t4_held_over", 13'(bus.sort_over), 13'd1);
    chk("t4_held_new1", bus.new1, mk(8'h11, 5'd12));
    chk("t4_held_new3", bus.new3, mk(8'h33, 5'd11));
    bus.sort_begin = 1'b0;
    cyc();

    // T5 start edge during S2 ignored
    bus.node1 = mk(8'h90, 5'd1); bus.node2 = mk(8'h50, 5'd2); bus.node3 = mk(8'h70, 5'd3);
    bus.sort_begin = 1'b1;
    cyc();                                   // start edge
    bus.sort_begin = 1'b0;
    cyc();                                   // E0
    cyc();                                   // E1 -> S2
    bus.sort_begin = 1'b1;
    cyc();                                   // E2 (edge ignored)
    bus.sort_begin = 1'b0;
    cyc();                                   // E3
    chk("t5_over", 13'(bus.sort_over), 13'd1);
    chk("t5_new1", bus.new1, mk(8'h50, 5'd2));
    chk("t5_new2", bus.new2, mk(8'h70, 5'd3));
    chk("t5_new3", bus.new3, mk(8'h90, 5'd1));
    repeat (3) cyc();
    chk("t5_stay_over", 13'(bus.sort_over), 13'd1);
    last1 = mk(8'h50, 5'd2); last2 = mk(8'h70, 5'd3); last3 = mk(8'h90, 5'd1);
    // re-sort from DONE: over held before E0, cleared at E0
    run_sort("t5b", mk(8'h03, 5'd21), mk(8'h02, 5'd22), mk(8'h01, 5'd23),
             mk(8'h01, 5'd23), mk(8'h02, 5'd22), mk(8'h03, 5'd21), 1'b0);
    cyc();

    // T6 reset during S2
    bus.node1 = mk(8'hA0, 5'd1); bus.node2 = mk(8'hB0, 5'd2); bus.node3 = mk(8'hC0, 5'd3);
    bus.sort_begin = 1'b1;
    cyc();
    bus.sort_begin = 1'b0;
    cyc();                                   // E0
    cyc();                                   // E1 -> S2
    nRST = 1'b0;
    #1;
    chk("t6_rst_over", 13'(bus.sort_over), 13'd0);
    chk("t6_rst_new1", bus.new1, 13'd0);
    chk("t6_rst_new2", bus.new2, 13'd0);
    chk("t6_rst_new3", bus.new3, 13'd0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (6) cyc();
    chk("t6_idle_over", 13'(bus.sort_over), 13'd0);
    chk("t6_idle_new1", bus.new1, 13'd0);
    last1 = '0; last2 = '0; last3 = '0; last_over = 1'b0;
    run_sort("t6b", mk(8'hC0, 5'd3), mk(8'hA0, 5'd1), mk(8'hB0, 5'd2),
             mk(8'hA0, 5'd1), mk(8'hB0, 5'd2), mk(8'hC0, 5'd3), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
